// File: rtl/sync_fifo_push_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_push_arbiter_if
//  Purpose  : Bundles the producer handshake, the sync_fifo write-side pins
//             and the arbiter status outputs into one interface.
//  Modports : master - arbiter side (drives ready, FIFO push/data/flush,
//                      grant_id, busy and, when enabled, stall_cnt)
//             slave  - producers / FIFO / observer side
//  Signals  : req_valid    [NUM_REQ]        producer i has a beat
//             req_data     [NUM_REQ*WIDTH]  producer i data at i*WIDTH
//             req_last     [NUM_REQ]        beat is last of the packet
//             req_ready    [NUM_REQ]        beat accepted on valid&&ready
//             flush_req                     one-cycle flush request pulse
//             fifo_full                     from sync_fifo full
//             fifo_push / fifo_data_in      to sync_fifo write port
//             fifo_flush                    to sync_fifo flush
//             grant_id     [$clog2(NUM_REQ)] current/last granted producer
//             busy                          arbiter not idle
//             stall_cnt    [16]             only with SYNC_FIFO_PUSH_ARB_STATS_EN
//  Config   : SYNC_FIFO_PUSH_ARB_STATS_EN adds the stall_cnt signal.
//  Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_push_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   localparam int c_grant_w = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_last;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     flush_req;
   logic                     fifo_full;
   logic                     fifo_push;
   logic [WIDTH-1:0]         fifo_data_in;
   logic                     fifo_flush;
   logic [c_grant_w-1:0]     grant_id;
   logic                     busy;
`ifdef SYNC_FIFO_PUSH_ARB_STATS_EN
   logic [15:0]              stall_cnt;

   modport master (
      input  req_valid, req_data, req_last, flush_req, fifo_full,
      output req_ready, fifo_push, fifo_data_in, fifo_flush, grant_id, busy,
             stall_cnt
   );

   modport slave (
      output req_valid, req_data, req_last, flush_req, fifo_full,
      input  req_ready, fifo_push, fifo_data_in, fifo_flush, grant_id, busy,
             stall_cnt
   );
`else
   modport master (
      input  req_valid, req_data, req_last, flush_req, fifo_full,
      output req_ready, fifo_push, fifo_data_in, fifo_flush, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, req_last, flush_req, fifo_full,
      input  req_ready, fifo_push, fifo_data_in, fifo_flush, grant_id, busy
   );
`endif
endinterface
`default_nettype wire

// File: rtl/sync_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_push_arbiter
//  Purpose  : Round-robin arbiter sharing the write port of one sync_fifo
//             among NUM_REQ producers. A producer is granted for a burst of
//             up to MAX_BURST beats, ending early on req_last or when the
//             producer drops valid. FIFO flush requests are sequenced
//             against in-flight bursts (a flush aborts the current burst).
//  Ports    : clk  - clock
//             rst  - synchronous reset, active-high
//             arb  - sync_fifo_push_arbiter_if.master (producer handshake,
//                    FIFO push/data/flush, grant_id, busy, optional stall_cnt)
//  Params   : NUM_REQ   number of producers (>=2)
//             WIDTH     data width, equal to the sync_fifo WIDTH
//             MAX_BURST max beats per grant (>=1)
//             The interface instance must use the same NUM_REQ and WIDTH.
//  Config   : SYNC_FIFO_PUSH_ARB_STATS_EN adds stall_cnt, a saturating count
//             of cycles in BURST where the granted producer is valid but the
//             FIFO is full. Cleared only by rst.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_push_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  wire logic                clk,
   input  wire logic                rst,
   sync_fifo_push_arbiter_if.master arb
);

   localparam int c_grant_w = $clog2(NUM_REQ);
   localparam int c_beat_w  = $clog2(MAX_BURST + 1);
   localparam int c_sum_w   = c_grant_w + 1;

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_burst = 2'd1;
   localparam logic [1:0] c_st_flush = 2'd2;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]           state_q,    state_d;
   logic [c_grant_w-1:0] grant_id_q, grant_id_d;
   logic [c_grant_w-1:0] rr_ptr_q,   rr_ptr_d;
   logic [c_beat_w-1:0]  beat_cnt_q, beat_cnt_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0]     w_req_data [NUM_REQ];
   logic                 w_sel_found;
   logic [c_grant_w-1:0] w_sel_idx;
   logic [c_sum_w-1:0]   w_cand;
   logic                 w_in_burst;
   logic                 w_g_valid;
   logic                 w_g_last;
   logic                 w_ready_g;
   logic                 w_push;
   logic                 w_burst_done;
   logic [c_grant_w-1:0] w_next_ptr;

   // Split the flat producer data bus into one word per producer.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_data[gi] = arb.req_data[gi*WIDTH +: WIDTH];
   end

   assign w_in_burst = (state_q == c_st_burst);
   assign w_g_valid  = arb.req_valid[grant_id_q];
   assign w_g_last   = arb.req_last[grant_id_q];

   // A flush request in BURST blocks the beat, so ready is withheld too:
   // otherwise the producer would see a handshake for a beat that never
   // reached the FIFO.
   assign w_ready_g  = w_in_burst && !arb.fifo_full && !arb.flush_req;
   assign w_push     = w_ready_g && w_g_valid;

   // The push that happens while the count is MAX_BURST-1 is the final beat.
   assign w_burst_done = (beat_cnt_q == c_beat_w'(MAX_BURST - 1));

   // Pointer to the producer after the current grant, wrapping at NUM_REQ-1
   // so non-power-of-2 NUM_REQ never produces an out-of-range index.
   assign w_next_ptr = (grant_id_q == c_grant_w'(NUM_REQ - 1)) ?
                       '0 : grant_id_q + 1'b1;

   // Round-robin search: first valid producer at or after rr_ptr_q, with
   // wrap. The candidate is computed one bit wider so the wrap subtraction
   // works for any NUM_REQ.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      w_cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, rr_ptr_q} + c_sum_w'(k);
         if (w_cand >= c_sum_w'(NUM_REQ)) begin
            w_cand = w_cand - c_sum_w'(NUM_REQ);
         end
         if (!w_sel_found && arb.req_valid[w_cand[c_grant_w-1:0]]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = w_cand[c_grant_w-1:0];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;

      case (state_q)
         c_st_idle: begin
            // Flush wins over a new grant. No beat is accepted in IDLE;
            // the grant becomes visible one cycle later.
            if (arb.flush_req) begin
               state_d = c_st_flush;
            end else if (w_sel_found && !arb.fifo_full) begin
               grant_id_d = w_sel_idx;
               beat_cnt_d = '0;
               state_d    = c_st_burst;
            end
         end

         c_st_burst: begin
            if (arb.flush_req) begin
               // Aborted burst still counts as served.
               state_d  = c_st_flush;
               rr_ptr_d = w_next_ptr;
            end else if (!w_g_valid) begin
               state_d  = c_st_idle;
               rr_ptr_d = w_next_ptr;
            end else if (w_push) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (w_g_last || w_burst_done) begin
                  state_d  = c_st_idle;
                  rr_ptr_d = w_next_ptr;
               end
            end
            // Valid but FIFO full: stall, everything held.
         end

         c_st_flush: begin
            // Single-cycle flush pulse; a flush_req seen here is ignored.
            state_d = c_st_idle;
         end

         default: begin
            state_d = c_st_idle;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= c_st_idle;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // Push and data are combinational from the granted producer so a beat
   // lands in the FIFO in the same cycle it is accepted.
   always_comb begin
      arb.req_ready             = '0;
      arb.req_ready[grant_id_q] = w_ready_g;
      arb.fifo_push             = w_push;
      arb.fifo_data_in          = w_in_burst ? w_req_data[grant_id_q] : '0;
      arb.fifo_flush            = (state_q == c_st_flush);
   end

   assign arb.grant_id = grant_id_q;
   assign arb.busy     = (state_q != c_st_idle);

`ifdef SYNC_FIFO_PUSH_ARB_STATS_EN
   // ------------------------------------------------------------------------
   // Stall statistics: cycles where the granted producer is blocked only by
   // a full FIFO. Saturates rather than wrapping; a flush does not clear it.
   // ------------------------------------------------------------------------
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (w_in_burst && w_g_valid && arb.fifo_full && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign arb.stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_push_arbiter
//  Purpose  : Self-checking bench for sync_fifo_push_arbiter. A reference
//             model predicts, per cycle, the arbiter outputs and the beats
//             that must reach the FIFO; a monitor compares the DUT against
//             those predictions. Directed scenarios are followed by a
//             randomized phase.
//  Config   : SYNC_FIFO_PUSH_ARB_STATS_EN enables the stall counter checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_push_arbiter;

   localparam int NR = 4;
   localparam int W  = 32;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sync_fifo_push_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

   sync_fifo_push_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .arb (bus)
   );

   typedef struct { bit [W-1:0] data; bit last; } pbeat_t;
   typedef struct { bit [NR-1:0] ready; bit push; bit flush; int grant; bit busy; int stall; } stat_t;
   typedef struct { bit is_flush; bit [W-1:0] data; } beat_t;

   pbeat_t pq [NR][$];   // per-producer beats still to be sent
   stat_t  stat_q[$];    // expected per-cycle outputs
   beat_t  beat_q[$];    // expected FIFO events in order

   int  total = 0;
   int  bad   = 0;
   bit  chk_en = 1'b0;

   bit [NR-1:0] nxt_mask  = '0;
   bit          nxt_full  = 1'b0;
   bit          nxt_flush = 1'b0;
   bit          nxt_rst   = 1'b1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: owner = producer holding the grant (-1 when none),
   // flushing = flush pulse being issued this cycle.
   // ------------------------------------------------------------------------
   int m_owner = -1;
   bit m_flushing = 1'b0;
   int m_ptr = 0;
   int m_beats = 0;
   int m_grant = 0;
   int m_stall = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin : model_cycle
            stat_t s;
            beat_t b;
            int g, n_owner, n_ptr, n_beats, n_grant, n_stall;
            bit n_flushing;
            s.ready = '0; s.push = 1'b0; s.flush = 1'b0;
            s.grant = m_grant;
            s.busy  = m_flushing || (m_owner >= 0);
            s.stall = m_stall;
            n_owner = m_owner; n_flushing = m_flushing; n_ptr = m_ptr;
            n_beats = m_beats; n_grant = m_grant; n_stall = m_stall;

            if (m_flushing) begin
               s.flush = 1'b1;
               n_flushing = 1'b0;
               b.is_flush = 1'b1; b.data = '0;
               beat_q.push_back(b);
            end else if (m_owner < 0) begin
               if (bus.flush_req) begin
                  n_flushing = 1'b1;
               end else if (bus.req_valid != 0 && !bus.fifo_full) begin
                  for (int k = 0; k < NR; k++) begin
                     int c;
                     c = (m_ptr + k) % NR;
                     if (n_owner < 0 && bus.req_valid[c]) begin
                        n_owner = c; n_grant = c; n_beats = 0;
                     end
                  end
               end
            end else begin
               g = m_owner;
               if (bus.req_valid[g] && bus.fifo_full && m_stall < 65535) n_stall = m_stall + 1;
               if (!bus.flush_req && !bus.fifo_full) s.ready[g] = 1'b1;
               if (bus.flush_req) begin
                  n_owner = -1; n_flushing = 1'b1; n_ptr = (g + 1) % NR;
               end else if (!bus.req_valid[g]) begin
                  n_owner = -1; n_ptr = (g + 1) % NR;
               end else if (!bus.fifo_full) begin
                  s.push = 1'b1;
                  b.is_flush = 1'b0; b.data = bus.req_data[g*W +: W];
                  beat_q.push_back(b);
                  n_beats = m_beats + 1;
                  if (bus.req_last[g] || n_beats == MB) begin
                     n_owner = -1; n_ptr = (g + 1) % NR;
                  end
               end
            end

            if (rst) begin
               n_owner = -1; n_flushing = 1'b0; n_ptr = 0; n_beats = 0;
               n_grant = 0; n_stall = 0;
            end
            stat_q.push_back(s);
            m_owner = n_owner; m_flushing = n_flushing; m_ptr = n_ptr;
            m_beats = n_beats; m_grant = n_grant; m_stall = n_stall;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Monitor: compares DUT outputs with the model's predictions each cycle
   // and pops the FIFO-event queue whenever the DUT pushes or flushes.
   // ------------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (chk_en && stat_q.size() > 0) begin : mon_cycle
            stat_t s;
            beat_t b;
            s = stat_q.pop_front();
            chk("req_ready",  bus.req_ready,  s.ready);
            chk("fifo_push",  bus.fifo_push,  s.push);
            chk("fifo_flush", bus.fifo_flush, s.flush);
            chk("grant_id",   bus.grant_id,   s.grant);
            chk("busy",       bus.busy,       s.busy);
            chk("no_push_when_full", bus.fifo_push & bus.fifo_full, 1'b0);
`ifdef SYNC_FIFO_PUSH_ARB_STATS_EN
            chk("stall_cnt",  bus.stall_cnt,  s.stall);
`endif
            if (bus.fifo_push || bus.fifo_flush) begin
               if (beat_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL beat_order: DUT push/flush with no expected event (t=%0t)", $time);
               end else begin
                  b = beat_q.pop_front();
                  chk("beat_kind", bus.fifo_flush, b.is_flush);
                  if (!b.is_flush) chk("beat_data", bus.fifo_data_in, b.data);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   // Advance one cycle: retire beats accepted in the current cycle, then
   // apply the nxt_* controls and present queue heads as the new inputs.
   task automatic step();
      bit [NR-1:0] acc;
      @(negedge clk);
      #2;
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      end
      rst           = nxt_rst;
      bus.flush_req = nxt_flush;
      bus.fifo_full = nxt_full;
      for (int i = 0; i < NR; i++) begin
         if (nxt_mask[i] && pq[i].size() > 0) begin
            bus.req_valid[i]       = 1'b1;
            bus.req_data[i*W +: W] = pq[i][0].data;
            bus.req_last[i]        = pq[i][0].last;
         end else begin
            bus.req_valid[i]       = 1'b0;
            bus.req_data[i*W +: W] = $urandom;
            bus.req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic load(input int p, input int n, input bit last_at_end);
      pbeat_t pb;
      for (int k = 0; k < n; k++) begin
         pb.data = {8'(p), 8'hC0, 16'(k)} ^ $urandom_range(0, 255);
         pb.last = last_at_end && (k == n - 1);
         pq[p].push_back(pb);
      end
   endtask

   task automatic do_reset();
      nxt_rst = 1'b1; nxt_mask = '0; nxt_flush = 1'b0; nxt_full = 1'b0;
      step();
      nxt_rst = 1'b0;
      step();
      for (int i = 0; i < NR; i++) pq[i].delete();
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int seq[$];
      int blen[$];
      bit prev_busy;
      int cnt;
      pbeat_t pb;

      rst = 1'b1;
      bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
      bus.flush_req = 1'b0; bus.fifo_full = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      settle();
      chk("reset_ready", bus.req_ready, '0);
      chk("reset_push",  bus.fifo_push, 1'b0);
      chk("reset_flush", bus.fifo_flush, 1'b0);
      chk("reset_grant", bus.grant_id, 0);
      chk("reset_busy",  bus.busy, 1'b0);
      nxt_rst = 1'b0;
      step();

      // --- Producer 0 sends A,B,C with last on C ---------------------------
      pb.data = 32'hAAAA_0001; pb.last = 1'b0; pq[0].push_back(pb);
      pb.data = 32'hBBBB_0002; pb.last = 1'b0; pq[0].push_back(pb);
      pb.data = 32'hCCCC_0003; pb.last = 1'b1; pq[0].push_back(pb);
      nxt_mask = 4'b0001;
      step(); settle();
      chk("t1_idle_no_ready", bus.req_ready, '0);
      step(); settle();
      chk("t1_grant", bus.grant_id, 0);
      chk("t1_data_a", bus.fifo_data_in, 32'hAAAA_0001);
      step(); settle();
      chk("t1_data_b", bus.fifo_data_in, 32'hBBBB_0002);
      step(); settle();
      chk("t1_data_c", bus.fifo_data_in, 32'hCCCC_0003);
      step(); settle();
      chk("t1_back_idle", bus.busy, 1'b0);
      chk("t1_all_sent", pq[0].size(), 0);
      // Pointer must now favour producer 1 over producer 0.
      load(0, 1, 1'b1); load(1, 1, 1'b1);
      nxt_mask = 4'b0011;
      step(); step(); settle();
      chk("t1_rr_ptr", bus.grant_id, 1);
      do_reset();

      // --- All producers valid, no last: 4-beat bursts 0,1,2,3,0 -----------
      for (int i = 0; i < NR; i++) load(i, 20, 1'b0);
      nxt_mask = 4'b1111;
      prev_busy = 1'b0;
      repeat (25) begin
         step(); settle();
         if (bus.busy && !prev_busy) begin
            seq.push_back(int'(bus.grant_id));
            blen.push_back(0);
         end
         if (bus.fifo_push && blen.size() > 0) blen[blen.size()-1] = blen[blen.size()-1] + 1;
         prev_busy = bus.busy;
      end
      chk("t2_burst_count", seq.size(), 5);
      for (int k = 0; k < seq.size() && k < 5; k++) chk($sformatf("t2_grant_%0d", k), seq[k], k % NR);
      for (int k = 0; k < blen.size() && k < 4; k++) chk($sformatf("t2_len_%0d", k), blen[k], MB);
      do_reset();

      // --- FIFO full for 5 cycles mid-burst ---------------------------------
      load(1, 8, 1'b0);
      nxt_mask = 4'b0010;
      cnt = 0;
      step();
      repeat (2) begin step(); settle(); if (bus.fifo_push) cnt++; end
      nxt_full = 1'b1;
      prev_busy = 1'b0;
      begin : t3_stall
         int stalled;
         stalled = 0;
         repeat (5) begin
            step(); settle();
            if (bus.busy && !bus.req_ready[1] && !bus.fifo_push) stalled++;
         end
         chk("t3_stall_cycles", stalled, 5);
      end
      nxt_full = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(); settle();
         if (bus.fifo_push) cnt++;
         if (!bus.busy) break;
      end
      chk("t3_total_beats", cnt, MB);
      do_reset();

      // --- Flush on the 2nd beat of a producer-2 burst ----------------------
      load(2, 6, 1'b0); load(3, 3, 1'b1);
      nxt_mask = 4'b0100;
      step();
      step(); settle();
      chk("t4_first_beat", bus.fifo_push, 1'b1);
      chk("t4_grant2", bus.grant_id, 2);
      nxt_flush = 1'b1;
      step(); settle();
      chk("t4_push_blocked", bus.fifo_push, 1'b0);
      chk("t4_ready_blocked", bus.req_ready, '0);
      step(); settle();   // flush_req still high here: must be ignored
      chk("t4_flush_pulse", bus.fifo_flush, 1'b1);
      nxt_flush = 1'b0;
      nxt_mask = 4'b1100;
      step(); settle();
      chk("t4_flush_one_cycle", bus.fifo_flush, 1'b0);
      chk("t4_idle_after_flush", bus.busy, 1'b0);
      step(); settle();
      chk("t4_next_grant", bus.grant_id, 3);
      do_reset();

      // --- Reset during a producer-1 burst ----------------------------------
      for (int i = 0; i < NR; i++) load(i, 8, 1'b0);
      nxt_mask = 4'b0010;
      step(); step(); step();
      nxt_rst = 1'b1; nxt_mask = 4'b1111;
      step();
      nxt_rst = 1'b0;
      step(); settle();
      chk("t5_ready", bus.req_ready, '0);
      chk("t5_push", bus.fifo_push, 1'b0);
      chk("t5_flush", bus.fifo_flush, 1'b0);
      chk("t5_grant", bus.grant_id, 0);
      chk("t5_busy", bus.busy, 1'b0);
      step(); settle();
      chk("t5_next_grant", bus.grant_id, 0);
      chk("t5_next_busy", bus.busy, 1'b1);
      do_reset();

`ifdef SYNC_FIFO_PUSH_ARB_STATS_EN
      // --- Stall counter: 10 cycles, then saturation ------------------------
      load(1, 4, 1'b0);
      nxt_mask = 4'b0010;
      step();
      nxt_full = 1'b1;
      repeat (10) step();
      step(); settle();
      chk("t6_stall_10", bus.stall_cnt, 16'd10);
      repeat (65540) step();
      settle();
      chk("t6_stall_sat", bus.stall_cnt, 16'hFFFF);
      do_reset();
`endif

      // --- Randomized traffic -----------------------------------------------
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (pq[i].size() < 2) load(i, $urandom_range(1, 6), 1'b1);
            nxt_mask[i] = ($urandom_range(0, 9) < 8);
         end
         nxt_full  = ($urandom_range(0, 3) == 0);
         nxt_flush = ($urandom_range(0, 39) == 0);
         nxt_rst   = ($urandom_range(0, 299) == 0);
         step();
      end
      nxt_mask = '0; nxt_full = 1'b0; nxt_flush = 1'b0; nxt_rst = 1'b0;
      repeat (6) step();
      settle();
      chk("drain_beats_outstanding", beat_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
